// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle control FSM for a single-bus MIPS-subset datapath.
// Decodes op/funct/zero into datapath controls on every cycle. Each output is a
// function of the current state and the instruction fields only; there are no
// Mealy paths from registered datapath results other than zero in EX. The
// block also counts retired instructions in instret.
// Optional build macro: ILLEGAL_TRAP_EN. When it is defined, an unknown
// instruction traps into HALT and sets the sticky illegal flag. When it is
// undefined, an unknown instruction retires as a NOP.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic [1:0]       npcop,
  output logic             PCWr,
  output logic             IRWr,
  output logic             RFWr,
  output logic             wren,
  output logic             sel,
  output logic [3:0]       aluop,
  output logic [1:0]       extop,
  output logic [1:0]       D_sel,
  output logic [1:0]       R_sel,
  output logic [2:0]       state,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             illegal
);

  localparam logic [2:0] S_IF   = 3'd0;
  localparam logic [2:0] S_ID   = 3'd1;
  localparam logic [2:0] S_EX   = 3'd2;
  localparam logic [2:0] S_MEM  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_HALT = 3'd5;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_SLT  = 4'b0100;
  localparam logic [3:0] ALU_PASS = 4'b0101;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0] next_state;
  logic       is_r_alu, is_jr, is_j, is_jal, is_addiu, is_ori, is_lui;
  logic       is_lw, is_sw, is_beq, is_i_alu, is_known;
  logic [3:0] r_aluop, i_aluop;
  logic [1:0] i_extop;

  // Instruction class decode; an R-type with an unrecognised funct is unknown.
  always_comb begin
    is_r_alu = 1'b0;
    r_aluop  = ALU_ADD;
    if (op == 6'b000000) begin
      case (funct)
        6'b100001: begin is_r_alu = 1'b1; r_aluop = ALU_ADD; end
        6'b100011: begin is_r_alu = 1'b1; r_aluop = ALU_SUB; end
        6'b100100: begin is_r_alu = 1'b1; r_aluop = ALU_AND; end
        6'b100101: begin is_r_alu = 1'b1; r_aluop = ALU_OR;  end
        6'b101010: begin is_r_alu = 1'b1; r_aluop = ALU_SLT; end
        default:   begin is_r_alu = 1'b0; r_aluop = ALU_ADD; end
      endcase
    end
    is_jr    = (op == 6'b000000) && (funct == 6'b001000);
    is_j     = (op == 6'b000010);
    is_jal   = (op == 6'b000011);
    is_addiu = (op == 6'b001001);
    is_ori   = (op == 6'b001101);
    is_lui   = (op == 6'b001111);
    is_lw    = (op == 6'b100011);
    is_sw    = (op == 6'b101011);
    is_beq   = (op == 6'b000100);
    is_i_alu = is_addiu | is_ori | is_lui;
    is_known = is_r_alu | is_jr | is_j | is_jal | is_i_alu | is_lw | is_sw | is_beq;
    // Immediate-ALU flavour: the extension mode and the ALU function travel together.
    i_extop = 2'b01;
    i_aluop = ALU_ADD;
    if (is_ori) begin
      i_extop = 2'b00;
      i_aluop = ALU_OR;
    end else if (is_lui) begin
      i_extop = 2'b10;
      i_aluop = ALU_PASS;
    end
  end

  // Moore control decode and next-state logic; everything is held at 0 while in reset.
  always_comb begin
    next_state = state;
    npcop      = 2'b00;
    PCWr       = 1'b0;
    IRWr       = 1'b0;
    RFWr       = 1'b0;
    wren       = 1'b0;
    sel        = 1'b0;
    aluop      = ALU_ADD;
    extop      = 2'b00;
    D_sel      = 2'b00;
    R_sel      = 2'b00;
    retire     = 1'b0;
    if (rst) begin
      case (state)
        S_IF: begin
          IRWr       = 1'b1;
          PCWr       = 1'b1;
          next_state = S_ID;
        end
        S_ID: begin
          if (is_j || is_jal) begin
            PCWr       = 1'b1;
            npcop      = 2'b10;
            retire     = 1'b1;
            next_state = S_IF;
            if (is_jal) begin
              // Link: write pc into $31.
              RFWr  = 1'b1;
              R_sel = 2'b00;
              D_sel = 2'b00;
            end
          end else if (!is_known) begin
`ifdef ILLEGAL_TRAP_EN
            next_state = S_HALT;
`else
            // PC was already advanced in IF, so retiring here is a NOP.
            retire     = 1'b1;
            next_state = S_IF;
`endif
          end else begin
            next_state = S_EX;
          end
        end
        S_EX: begin
          if (is_r_alu) begin
            sel        = 1'b0;
            aluop      = r_aluop;
            next_state = S_WB;
          end else if (is_jr) begin
            PCWr       = 1'b1;
            npcop      = 2'b11;
            retire     = 1'b1;
            next_state = S_IF;
          end else if (is_i_alu) begin
            sel        = 1'b1;
            extop      = i_extop;
            aluop      = i_aluop;
            next_state = S_WB;
          end else if (is_lw || is_sw) begin
            sel        = 1'b1;
            extop      = 2'b01;
            aluop      = ALU_ADD;
            next_state = S_MEM;
          end else if (is_beq) begin
            sel        = 1'b0;
            aluop      = ALU_SUB;
            npcop      = 2'b01;
            PCWr       = zero;
            retire     = 1'b1;
            next_state = S_IF;
          end else begin
            next_state = S_IF;
          end
        end
        S_MEM: begin
          if (is_sw) begin
            wren       = 1'b1;
            sel        = 1'b0;
            retire     = 1'b1;
            next_state = S_IF;
          end else if (is_lw) begin
            next_state = S_WB;
          end else begin
            next_state = S_IF;
          end
        end
        S_WB: begin
          RFWr       = 1'b1;
          retire     = 1'b1;
          next_state = S_IF;
          if (is_lw) begin
            D_sel = 2'b10;
            R_sel = 2'b01;
            sel   = 1'b1;
            extop = 2'b01;
            aluop = ALU_ADD;
          end else if (is_i_alu) begin
            D_sel = 2'b01;
            R_sel = 2'b01;
            sel   = 1'b1;
            extop = i_extop;
            aluop = i_aluop;
          end else begin
            D_sel = 2'b01;
            R_sel = 2'b10;
            sel   = 1'b0;
            aluop = r_aluop;
          end
        end
        S_HALT: begin
          next_state = S_HALT;
        end
        default: begin
          next_state = S_IF;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IF;
    end else begin
      state <= next_state;
    end
  end

  // Retired-instruction counter; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instret <= '0;
    end else if (retire) begin
      instret <= instret + CNT_ONE;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  // Sticky trap flag, set on leaving ID with an unknown instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      illegal <= 1'b0;
    end else if (state == S_ID && !is_known) begin
      illegal <= 1'b1;
    end
  end
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: expected per-cycle state/control records are
// queued as each instruction is presented and popped as the DUT steps.
module tb_multicycle_ctrl;

  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic [5:0]    op;
  logic [5:0]    funct;
  logic          zero;
  logic [1:0]    npcop;
  logic          PCWr, IRWr, RFWr, wren, sel;
  logic [3:0]    aluop;
  logic [1:0]    extop, D_sel, R_sel;
  logic [2:0]    state;
  logic          retire;
  logic [CW-1:0] instret;
  logic          illegal;

  multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
    .npcop(npcop), .PCWr(PCWr), .IRWr(IRWr), .RFWr(RFWr), .wren(wren),
    .sel(sel), .aluop(aluop), .extop(extop), .D_sel(D_sel), .R_sel(R_sel),
    .state(state), .retire(retire), .instret(instret), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  st;
    logic [16:0] ctl;
    logic        ret;
    logic        ill;
  } exp_t;

  exp_t          sb[$];
  int            n_vec = 0;
  int            n_err = 0;
  logic [CW-1:0] exp_cnt;
  logic [16:0]   ctl_obs;

  assign ctl_obs = {npcop, PCWr, IRWr, RFWr, wren, sel, aluop, extop, D_sel, R_sel};

  function automatic logic [16:0] cv(input logic [1:0] np, input logic pw, input logic iw,
                                     input logic rw, input logic we, input logic sl,
                                     input logic [3:0] al, input logic [1:0] ex,
                                     input logic [1:0] ds, input logic [1:0] rs);
    return {np, pw, iw, rw, we, sl, al, ex, ds, rs};
  endfunction

  task automatic push(input logic [2:0] st, input logic [16:0] c, input logic r, input logic il);
    exp_t e;
    e.st = st; e.ctl = c; e.ret = r; e.ill = il;
    sb.push_back(e);
  endtask

  task automatic push_if();
    push(3'd0, cv(2'b00, 1, 1, 0, 0, 0, 4'd0, 2'b00, 2'b00, 2'b00), 0, 0);
  endtask

  task automatic push_id();
    push(3'd1, 17'd0, 0, 0);
  endtask

  task automatic test_reset();
    op = 6'b000000; funct = 6'b100001; zero = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_vec++;
      if (state !== 3'd0 || ctl_obs !== 17'd0 || retire !== 1'b0 || instret !== '0 || illegal !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold: state=%0d ctl=%h retire=%b instret=%0d illegal=%b, want 0/0/0/0/0",
                 state, ctl_obs, retire, instret, illegal);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    exp_cnt = '0;
    $display("reset released");
  endtask

  task automatic test_rtype();
    logic [5:0] fn [5] = '{6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b101010};
    logic [3:0] al [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    exp_t e;
    for (int k = 0; k < 5; k++) begin
      op = 6'b000000; funct = fn[k];
      push_if(); push_id();
      push(3'd2, cv(2'b00, 0, 0, 0, 0, 0, al[k], 2'b00, 2'b00, 2'b00), 0, 0);
      push(3'd4, cv(2'b00, 0, 0, 1, 0, 0, al[k], 2'b00, 2'b01, 2'b10), 1, 0);
      while (sb.size() != 0) begin
        e = sb.pop_front();
        #1;
        n_vec++;
        if (state !== e.st) begin n_err++; $display("FAIL rtype_state: got %0d want %0d", state, e.st); end
        if (ctl_obs !== e.ctl) begin n_err++; $display("FAIL rtype_ctl st%0d: got %h want %h", e.st, ctl_obs, e.ctl); end
        if (retire !== e.ret) begin n_err++; $display("FAIL rtype_retire st%0d: got %b want %b", e.st, retire, e.ret); end
        if (instret !== exp_cnt) begin n_err++; $display("FAIL rtype_instret: got %0d want %0d", instret, exp_cnt); end
        if (e.ret) exp_cnt++;
        @(negedge clk);
      end
      $display("rtype funct=%b done, instret=%0d", fn[k], instret);
    end
  endtask

  task automatic test_itype();
    logic [5:0] oc [3] = '{6'b001001, 6'b001101, 6'b001111};
    logic [1:0] ex [3] = '{2'b01, 2'b00, 2'b10};
    logic [3:0] al [3] = '{4'd0, 4'd3, 4'd5};
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      op = oc[k]; funct = 6'b000000;
      push_if(); push_id();
      push(3'd2, cv(2'b00, 0, 0, 0, 0, 1, al[k], ex[k], 2'b00, 2'b00), 0, 0);
      push(3'd4, cv(2'b00, 0, 0, 1, 0, 1, al[k], ex[k], 2'b01, 2'b01), 1, 0);
      while (sb.size() != 0) begin
        e = sb.pop_front();
        #1;
        n_vec++;
        if (state !== e.st) begin n_err++; $display("FAIL itype_state: got %0d want %0d", state, e.st); end
        if (ctl_obs !== e.ctl) begin n_err++; $display("FAIL itype_ctl st%0d: got %h want %h", e.st, ctl_obs, e.ctl); end
        if (retire !== e.ret) begin n_err++; $display("FAIL itype_retire st%0d: got %b want %b", e.st, retire, e.ret); end
        if (instret !== exp_cnt) begin n_err++; $display("FAIL itype_instret: got %0d want %0d", instret, exp_cnt); end
        if (e.ret) exp_cnt++;
        @(negedge clk);
      end
      $display("itype op=%b done, instret=%0d", oc[k], instret);
    end
  endtask

  task automatic test_load_store();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        // lw $5,4($0)
        op = 6'b100011; funct = 6'b000100;
        push_if(); push_id();
        push(3'd2, cv(2'b00, 0, 0, 0, 0, 1, 4'd0, 2'b01, 2'b00, 2'b00), 0, 0);
        push(3'd3, 17'd0, 0, 0);
        push(3'd4, cv(2'b00, 0, 0, 1, 0, 1, 4'd0, 2'b01, 2'b10, 2'b01), 1, 0);
      end else begin
        // sw $5,8($0)
        op = 6'b101011; funct = 6'b001000;
        push_if(); push_id();
        push(3'd2, cv(2'b00, 0, 0, 0, 0, 1, 4'd0, 2'b01, 2'b00, 2'b00), 0, 0);
        push(3'd3, cv(2'b00, 0, 0, 0, 1, 0, 4'd0, 2'b00, 2'b00, 2'b00), 1, 0);
      end
      while (sb.size() != 0) begin
        e = sb.pop_front();
        #1;
        n_vec++;
        if (state !== e.st) begin n_err++; $display("FAIL ldst_state: got %0d want %0d", state, e.st); end
        if (ctl_obs !== e.ctl) begin n_err++; $display("FAIL ldst_ctl st%0d: got %h want %h", e.st, ctl_obs, e.ctl); end
        if (retire !== e.ret) begin n_err++; $display("FAIL ldst_retire st%0d: got %b want %b", e.st, retire, e.ret); end
        if (instret !== exp_cnt) begin n_err++; $display("FAIL ldst_instret: got %0d want %0d", instret, exp_cnt); end
        if (e.ret) exp_cnt++;
        @(negedge clk);
      end
      $display("%s done, instret=%0d", (k == 0) ? "lw" : "sw", instret);
    end
  endtask

  task automatic test_branch();
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (k < 2) begin
        // beq with zero=1 then zero=0
        op = 6'b000100; funct = 6'b000011; zero = (k == 0);
        push_if(); push_id();
        push(3'd2, cv(2'b01, (k == 0), 0, 0, 0, 0, 4'd1, 2'b00, 2'b00, 2'b00), 1, 0);
      end else begin
        op = 6'b000000; funct = 6'b001000; zero = 1'b1;
        push_if(); push_id();
        push(3'd2, cv(2'b11, 1, 0, 0, 0, 0, 4'd0, 2'b00, 2'b00, 2'b00), 1, 0);
      end
      while (sb.size() != 0) begin
        e = sb.pop_front();
        #1;
        n_vec++;
        if (state !== e.st) begin n_err++; $display("FAIL branch_state: got %0d want %0d", state, e.st); end
        if (ctl_obs !== e.ctl) begin n_err++; $display("FAIL branch_ctl st%0d: got %h want %h", e.st, ctl_obs, e.ctl); end
        if (retire !== e.ret) begin n_err++; $display("FAIL branch_retire st%0d: got %b want %b", e.st, retire, e.ret); end
        if (instret !== exp_cnt) begin n_err++; $display("FAIL branch_instret: got %0d want %0d", instret, exp_cnt); end
        if (e.ret) exp_cnt++;
        @(negedge clk);
      end
      $display("branch case %0d (op=%b zero=%b) done, instret=%0d", k, op, zero, instret);
    end
    zero = 1'b0;
  endtask

  // j, jal, then a run of back-to-back j that carries instret through its wrap.
  task automatic test_jump();
    exp_t e;
    for (int k = 0; k < 20; k++) begin
      if (k == 1) begin
        op = 6'b000011; funct = 6'b010000;
        push_if();
        push(3'd1, cv(2'b10, 1, 0, 1, 0, 0, 4'd0, 2'b00, 2'b00, 2'b00), 1, 0);
      end else begin
        op = 6'b000010; funct = 6'b000000;
        push_if();
        push(3'd1, cv(2'b10, 1, 0, 0, 0, 0, 4'd0, 2'b00, 2'b00, 2'b00), 1, 0);
      end
      while (sb.size() != 0) begin
        e = sb.pop_front();
        #1;
        n_vec++;
        if (state !== e.st) begin n_err++; $display("FAIL jump_state: got %0d want %0d", state, e.st); end
        if (ctl_obs !== e.ctl) begin n_err++; $display("FAIL jump_ctl st%0d: got %h want %h", e.st, ctl_obs, e.ctl); end
        if (retire !== e.ret) begin n_err++; $display("FAIL jump_retire st%0d: got %b want %b", e.st, retire, e.ret); end
        if (instret !== exp_cnt) begin n_err++; $display("FAIL jump_instret: got %0d want %0d", instret, exp_cnt); end
        if (e.ret) exp_cnt++;
        @(negedge clk);
      end
      $display("jump %0d op=%b done, instret=%0d", k, op, instret);
    end
  endtask

  task automatic test_reset_abort();
    exp_t e;
    op = 6'b000000; funct = 6'b100001;
    push_if(); push_id();
    while (sb.size() != 0) begin
      e = sb.pop_front();
      #1;
      n_vec++;
      if (state !== e.st) begin n_err++; $display("FAIL abort_state: got %0d want %0d", state, e.st); end
      if (ctl_obs !== e.ctl) begin n_err++; $display("FAIL abort_ctl st%0d: got %h want %h", e.st, ctl_obs, e.ctl); end
      if (instret !== exp_cnt) begin n_err++; $display("FAIL abort_instret: got %0d want %0d", instret, exp_cnt); end
      @(negedge clk);
    end
    // Now in EX: pull reset asynchronously, away from any clock edge.
    #2 rst = 1'b0;
    #1;
    n_vec++;
    if (state !== 3'd0 || ctl_obs !== 17'd0 || retire !== 1'b0 || instret !== '0) begin
      n_err++;
      $display("FAIL abort_reset: state=%0d ctl=%h retire=%b instret=%0d, want 0/0/0/0",
               state, ctl_obs, retire, instret);
    end
    @(negedge clk);
    rst = 1'b1;
    exp_cnt = '0;
    $display("reset abort in EX done");
  endtask

  task automatic test_illegal();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      op = (k == 0) ? 6'b111111 : 6'b000000;
      funct = 6'b111111;
      push_if();
`ifdef ILLEGAL_TRAP_EN
      push(3'd1, 17'd0, 0, 0);
      for (int h = 0; h < 20; h++) push(3'd5, 17'd0, 0, 1);
`else
      push(3'd1, 17'd0, 1, 0);
`endif
      while (sb.size() != 0) begin
        e = sb.pop_front();
        #1;
        n_vec++;
        if (state !== e.st) begin n_err++; $display("FAIL illegal_state: got %0d want %0d", state, e.st); end
        if (ctl_obs !== e.ctl) begin n_err++; $display("FAIL illegal_ctl st%0d: got %h want %h", e.st, ctl_obs, e.ctl); end
        if (retire !== e.ret) begin n_err++; $display("FAIL illegal_retire st%0d: got %b want %b", e.st, retire, e.ret); end
        if (illegal !== e.ill) begin n_err++; $display("FAIL illegal_flag st%0d: got %b want %b", e.st, illegal, e.ill); end
        if (instret !== exp_cnt) begin n_err++; $display("FAIL illegal_instret: got %0d want %0d", instret, exp_cnt); end
        if (e.ret) exp_cnt++;
        @(negedge clk);
      end
`ifdef ILLEGAL_TRAP_EN
      rst = 1'b0;
      #1;
      n_vec++;
      if (state !== 3'd0 || illegal !== 1'b0) begin
        n_err++;
        $display("FAIL illegal_clear: state=%0d illegal=%b, want 0/0", state, illegal);
      end
      @(negedge clk);
      rst = 1'b1;
      exp_cnt = '0;
`endif
      $display("unknown op=%b funct=%b done, instret=%0d", op, funct, instret);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_cnt = '0;
    test_reset();
    test_rtype();
    test_itype();
    test_load_store();
    test_branch();
    test_jump();
    test_reset_abort();
    test_illegal();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
